// File: rtl/wb_stage.sv
// MEM/WB stage register and register-file write-back.
// Optional decode bypass enabled by defining WB_BYPASS_EN.
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              valid_in,
  input  logic              wb_enable_in,
  input  logic              mem_read_in,
  input  logic [ADDR_W-1:0] dest_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic              writeBackEn,
  output logic [ADDR_W-1:0] Dest_wb,
  output logic [DATA_W-1:0] Result_wb,
  output logic              pc_write,
  output logic              pending_valid,
  output logic [ADDR_W-1:0] pending_dest,
  output logic [31:0]       retired,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic [ADDR_W-1:0] id_src2,
  output logic              byp1_hit,
  output logic              byp2_hit,
  output logic [DATA_W-1:0] byp_value
);

  logic              valid_q;
  logic              wb_en_q;
  logic              mem_rd_q;
  logic [ADDR_W-1:0] dest_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] mem_q;
  logic [31:0]       ret_q;

  logic              commit;
  logic              pc_tgt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      wb_en_q  <= 1'b0;
      mem_rd_q <= 1'b0;
      dest_q   <= '0;
      alu_q    <= '0;
      mem_q    <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
    end else if (!freeze) begin
      valid_q  <= valid_in;
      wb_en_q  <= wb_enable_in;
      mem_rd_q <= mem_read_in;
      dest_q   <= dest_in;
      alu_q    <= alu_result_in;
      mem_q    <= mem_data_in;
    end
  end

  // An entry retires on the one unfrozen cycle it is presented.
  always_ff @(posedge clk) begin
    if (!rst)
      ret_q <= '0;
    else if (valid_q && !freeze)
      ret_q <= ret_q + 32'd1;
  end

  assign pc_tgt        = &dest_q;
  assign commit        = valid_q & wb_en_q & ~freeze;

  assign writeBackEn   = commit & ~pc_tgt;
  assign pc_write      = commit & pc_tgt;
  assign Dest_wb       = dest_q;
  assign Result_wb     = mem_rd_q ? mem_q : alu_q;
  assign pending_valid = valid_q & wb_en_q;
  assign pending_dest  = dest_q;
  assign retired       = ret_q;

`ifdef WB_BYPASS_EN
  assign byp1_hit  = writeBackEn & (id_src1 == Dest_wb);
  assign byp2_hit  = writeBackEn & (id_src2 == Dest_wb);
  assign byp_value = Result_wb;
`else
  logic unused_src;
  assign unused_src = ^{id_src1, id_src2};
  assign byp1_hit   = 1'b0;
  assign byp2_hit   = 1'b0;
  assign byp_value  = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios
// plus randomized traffic against a behavioural model.
module tb_wb_stage;

  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze;
  logic          flush;
  logic          valid_in;
  logic          wb_enable_in;
  logic          mem_read_in;
  logic [AW-1:0] dest_in;
  logic [DW-1:0] alu_result_in;
  logic [DW-1:0] mem_data_in;
  logic          writeBackEn;
  logic [AW-1:0] Dest_wb;
  logic [DW-1:0] Result_wb;
  logic          pc_write;
  logic          pending_valid;
  logic [AW-1:0] pending_dest;
  logic [31:0]   retired;
  logic [AW-1:0] id_src1;
  logic [AW-1:0] id_src2;
  logic          byp1_hit;
  logic          byp2_hit;
  logic [DW-1:0] byp_value;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 0;

  always #5 clk = ~clk;

  wb_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .flush        (flush),
    .valid_in     (valid_in),
    .wb_enable_in (wb_enable_in),
    .mem_read_in  (mem_read_in),
    .dest_in      (dest_in),
    .alu_result_in(alu_result_in),
    .mem_data_in  (mem_data_in),
    .writeBackEn  (writeBackEn),
    .Dest_wb      (Dest_wb),
    .Result_wb    (Result_wb),
    .pc_write     (pc_write),
    .pending_valid(pending_valid),
    .pending_dest (pending_dest),
    .retired      (retired),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .byp1_hit     (byp1_hit),
    .byp2_hit     (byp2_hit),
    .byp_value    (byp_value)
  );

  // Reference: the held instruction as a record, plus a retire tally.
  bit          m_valid = 0;
  bit          m_wb    = 0;
  bit          m_mr    = 0;
  int unsigned m_dest  = 0;
  int unsigned m_alu   = 0;
  int unsigned m_mem   = 0;
  int unsigned m_ret   = 0;

  always @(posedge clk) begin
    if (rst !== 1'b1) begin
      m_valid = 0; m_wb = 0; m_mr = 0;
      m_dest = 0; m_alu = 0; m_mem = 0; m_ret = 0;
    end else begin
      if (m_valid && !freeze) m_ret = m_ret + 1;
      if (flush) m_valid = 0;
      else if (!freeze) begin
        m_valid = valid_in;
        m_wb    = wb_enable_in;
        m_mr    = mem_read_in;
        m_dest  = dest_in;
        m_alu   = alu_result_in;
        m_mem   = mem_data_in;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    bit          writes;
    bit          to_pc;
    bit          e_wbe;
    int unsigned e_res;
    bit          e_b1;
    bit          e_b2;
    int unsigned e_bv;
    writes = m_valid && m_wb && !freeze;
    to_pc  = (m_dest == 15);
    e_wbe  = writes && !to_pc;
    e_res  = m_mr ? m_mem : m_alu;
`ifdef WB_BYPASS_EN
    e_b1 = e_wbe && (id_src1 == m_dest);
    e_b2 = e_wbe && (id_src2 == m_dest);
    e_bv = e_res;
`else
    e_b1 = 0;
    e_b2 = 0;
    e_bv = 0;
`endif
    check("m_wbe",    64'(writeBackEn),   64'(e_wbe));
    check("m_pcw",    64'(pc_write),      64'(writes && to_pc));
    check("m_dest",   64'(Dest_wb),       64'(m_dest));
    check("m_res",    64'(Result_wb),     64'(e_res));
    check("m_pvalid", 64'(pending_valid), 64'(m_valid && m_wb));
    check("m_pdest",  64'(pending_dest),  64'(m_dest));
    check("m_ret",    64'(retired),       64'(m_ret));
    check("m_b1",     64'(byp1_hit),      64'(e_b1));
    check("m_b2",     64'(byp2_hit),      64'(e_b2));
    check("m_bv",     64'(byp_value),     64'(e_bv));
  endtask

  initial begin
    @(negedge clk);
    while (!done) begin
      compare_model();
      @(negedge clk);
    end
  end

  // One rising edge passes; land just after the falling edge.
  task automatic go();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input bit v, input bit we, input bit mr,
                     input int unsigned d, input int unsigned alu,
                     input int unsigned mem);
    valid_in      = v;
    wb_enable_in  = we;
    mem_read_in   = mr;
    dest_in       = AW'(d);
    alu_result_in = alu;
    mem_data_in   = mem;
  endtask

  logic [31:0] r0;
  bit          exp_byp;

  initial begin
    rst = 0; freeze = 0; flush = 0;
    id_src1 = 0; id_src2 = 0;
    put(0, 0, 0, 0, 0, 0);
    go(); go();
    check("rst_wbe",  64'(writeBackEn),   64'd0);
    check("rst_res",  64'(Result_wb),     64'd0);
    check("rst_ret",  64'(retired),       64'd0);
    check("rst_pval", 64'(pending_valid), 64'd0);

    rst = 1;
    put(1, 1, 0, 3, 32'h2A, 32'h0);
    go();
    check("alu_wbe",  64'(writeBackEn), 64'd1);
    check("alu_dest", 64'(Dest_wb),     64'd3);
    check("alu_res",  64'(Result_wb),   64'h2A);
    check("alu_ret0", 64'(retired),     64'd0);
    put(0, 0, 0, 0, 0, 0);
    go();
    check("alu_ret1", 64'(retired),     64'd1);

    put(1, 1, 1, 5, 32'h10, 32'hDEADBEEF);
    go();
    check("load_res", 64'(Result_wb), 64'hDEADBEEF);

    put(1, 1, 0, 15, 32'h100, 32'h0);
    go();
    check("r15_pcw",  64'(pc_write),      64'd1);
    check("r15_wbe",  64'(writeBackEn),   64'd0);
    check("r15_pd",   64'(pending_dest),  64'd15);
    check("r15_pv",   64'(pending_valid), 64'd1);

    put(1, 1, 0, 9, 32'h99, 32'h0);
    go();
    r0 = retired;
    freeze = 1;
    put(1, 1, 0, 4, 32'h44, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("frz_wbe", 64'(writeBackEn), 64'd0);
      go();
      check("frz_dest", 64'(Dest_wb), 64'd9);
    end
    check("frz_ret", 64'(retired), 64'(r0));
    freeze = 0;
    put(0, 0, 0, 0, 0, 0);
    #1;
    check("rel_wbe",  64'(writeBackEn), 64'd1);
    check("rel_res",  64'(Result_wb),   64'h99);
    go();
    check("rel_ret",  64'(retired),     64'(r0 + 1));
    check("rel_wbe0", 64'(writeBackEn), 64'd0);

    put(1, 1, 0, 6, 32'h66, 32'h0);
    go();
    r0 = retired;
    flush = 1; freeze = 1;
    go();
    check("ff_wbe", 64'(writeBackEn),   64'd0);
    check("ff_pv",  64'(pending_valid), 64'd0);
    check("ff_ret", 64'(retired),       64'(r0));
    flush = 0; freeze = 0;
    put(0, 0, 0, 0, 0, 0);
    go();
    check("ff_ret2", 64'(retired), 64'(r0));

    put(1, 1, 1, 2, 32'h22, 32'h33);
    go();
    rst = 0;
    go();
    check("mrst_wbe",  64'(writeBackEn), 64'd0);
    check("mrst_dest", 64'(Dest_wb),     64'd0);
    check("mrst_res",  64'(Result_wb),   64'd0);
    check("mrst_ret",  64'(retired),     64'd0);
    rst = 1;

    put(1, 1, 0, 7, 32'h77, 32'h0);
    go();
    id_src1 = 7; id_src2 = 2;
    #1;
`ifdef WB_BYPASS_EN
    exp_byp = 1;
`else
    exp_byp = 0;
`endif
    check("byp1", 64'(byp1_hit),  64'(exp_byp));
    check("byp2", 64'(byp2_hit),  64'd0);
    check("bypv", 64'(byp_value), exp_byp ? 64'h77 : 64'd0);

    for (int c = 0; c < 600; c++) begin
      rst     = ($urandom_range(0, 39) != 0);
      freeze  = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      id_src1 = AW'($urandom_range(0, 15));
      id_src2 = AW'($urandom_range(0, 15));
      put($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 15),
          $urandom, $urandom);
      go();
    end

    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DATA_W, default 32, register and data word width.
REQ-002 Parameter ADDR_W, default 4, register-file address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-005 freeze  input  1  hold the stage register; no capture, no retire.
REQ-006 flush  input  1  invalidate the stage register at the next edge.
REQ-007 valid_in  input  1  MEM/WB entry presented this cycle is a real instruction.
REQ-008 wb_enable_in  input  1  instruction writes a register.
REQ-009 mem_read_in  input  1  result is load data, not ALU result.
REQ-010 dest_in  input  ADDR_W  destination register (Rd).
REQ-011 alu_result_in  input  DATA_W  ALU result.
REQ-012 mem_data_in  input  DATA_W  load data.
REQ-013 writeBackEn  output  1  register-file write strobe.
REQ-014 Dest_wb  output  ADDR_W  register-file write address.
REQ-015 Result_wb  output  DATA_W  register-file write data.
REQ-016 pc_write  output  1  write targets r15; goes to fetch, not register file.
REQ-017 pending_valid / pending_dest  output  1 / ADDR_W  held write target, for the hazard unit.
REQ-018 retired  output  32  count of retired instructions.
REQ-019 id_src1, id_src2  input  ADDR_W  decode-stage source addresses.
REQ-020 byp1_hit, byp2_hit  output  1  bypass match per source.
REQ-021 byp_value  output  DATA_W  bypass data.

Function
REQ-022 The stage SHALL hold one entry: valid, wb_enable, mem_read, dest, alu_result, mem_data.
REQ-023 Capture at each edge: flush=1 -> valid<=0 (flush beats freeze); else freeze=1 -> hold all fields; else capture all inputs, valid<=valid_in.
REQ-024 Latency SHALL be exactly 1 cycle from input capture to writeBackEn.
REQ-025 Result_wb SHALL equal mem_data if mem_read, else alu_result; it is combinational from stored fields.
REQ-026 Dest_wb SHALL equal the stored dest.
REQ-027 writeBackEn SHALL equal valid & wb_enable & (dest != all-ones) & ~freeze.
REQ-028 pc_write SHALL equal valid & wb_enable & (dest == all-ones) & ~freeze; never asserted together with writeBackEn.
REQ-029 pending_valid SHALL equal valid & wb_enable, including r15 targets; pending_dest equals the stored dest.
REQ-030 retired SHALL increment by 1 on each edge where valid=1, freeze=0 and rst=1; it wraps from 0xFFFFFFFF to 0.
REQ-031 An entry held under freeze for N cycles SHALL write and retire once only, in the first unfrozen cycle.
REQ-032 Flush and freeze together SHALL clear valid; the entry being dropped is not retired if freeze was high that cycle.

Reset
REQ-033 At an edge with rst=0 all stored fields SHALL clear to 0 and retired SHALL clear to 0, overriding flush and freeze.
REQ-034 After reset, every output SHALL be 0 until the first captured valid entry.
REQ-035 Reset while an entry is pending SHALL drop it with no write and no retire.

Configuration
REQ-036 Macro WB_BYPASS_EN: defined -> byp1_hit = writeBackEn & (id_src1 == Dest_wb), byp2_hit likewise for id_src2, byp_value = Result_wb.
REQ-037 WB_BYPASS_EN not defined -> the ports remain present; byp1_hit, byp2_hit and byp_value are tied to 0.

Verification
REQ-038 Reset, then valid_in=1, wb_enable_in=1, mem_read_in=0, dest_in=3, alu_result_in=0x2A -> next cycle writeBackEn=1, Dest_wb=3, Result_wb=0x2A, retired=1 one edge later.
REQ-039 mem_read_in=1, mem_data_in=0xDEADBEEF, alu_result_in=0x10, dest_in=5 -> Result_wb=0xDEADBEEF.
REQ-040 dest_in=15, wb_enable_in=1 -> pc_write=1, writeBackEn=0, pending_dest=15.
REQ-041 Entry captured, then freeze=1 for 3 cycles -> writeBackEn=0 throughout; one write on release; retired increases by exactly 1.
REQ-042 flush=1 together with freeze=1 -> valid cleared next cycle, no write; separately, rst=0 mid-entry -> all outputs 0 and retired=0.
REQ-043 WB_BYPASS_EN defined, write to r7 active, id_src1=7, id_src2=2 -> byp1_hit=1, byp2_hit=0, byp_value=Result_wb; macro undefined -> all 0.
